// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the segmented add/sub pipeline.
//   ADDSUB_WIDTH  default operand/result width
//   ADDSUB_SEG    default segment width resolved per pipeline stage
//   addsub_nstage number of pipeline stages for a given WIDTH/SEG
package addsub_pkg;

  localparam int unsigned ADDSUB_WIDTH = 64;
  localparam int unsigned ADDSUB_SEG   = 16;

  // One stage per segment; never fewer than one stage.
  function automatic int unsigned addsub_nstage(input int unsigned width,
                                                input int unsigned seg);
    int unsigned n;
    n = (seg == 0) ? 1 : (width / seg);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// Combinational SEG-bit carry-lookahead adder segment.
//   a, b  segment operands (b already conditionally inverted by the caller)
//   cin   carry into the segment LSB
//   s     segment sum
//   cout  carry out of the segment MSB
//   cmsb  carry into the segment MSB (used for signed overflow)
module addsub_seg #(
  parameter int unsigned SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is formed from the group generate/propagate of bits [i:0],
  // so every c[i+1] is a flat function of g, p and cin.
  always_comb begin
    logic gg;
    logic pp;
    c    = '0;
    c[0] = cin;
    gg   = 1'b0;
    pp   = 1'b1;
    for (int unsigned i = 0; i < SEG; i++) begin
      gg       = g[i] | (p[i] & gg);
      pp       = pp & p[i];
      c[i+1]   = gg | (pp & cin);
    end
  end

  assign s    = p ^ c[SEG-1:0];
  assign cout = c[SEG];
  assign cmsb = c[SEG-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined integer adder/subtractor. Operands are split into SEG-bit
// segments; stage k resolves segment k with the carry registered by stage k-1,
// so latency is NSTAGE = WIDTH/SEG cycles at one operation per cycle.
//   clk, rst        clock, synchronous active-high reset (clears data too)
//   flush           squash all in-flight operations (data left as is)
//   in_valid/ready  input handshake for a, b, cin, sub
//   a, b            operands; sub=1 computes a + ~b + (sub ^ cin)
//   out_valid/ready output handshake
//   s               result
//   cout            carry out of MSB (subtract: 1 = no borrow)
//   ovf             two's-complement signed overflow
//   zero            s == 0
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_WIDTH,
  parameter int unsigned SEG   = ADDSUB_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSTAGE = addsub_nstage(WIDTH, SEG);

  // Per-stage state. w_q holds resolved result segments 0..k in its low part
  // and the still-pending a segments above them, so one word carries both.
  logic [NSTAGE-1:0]            valid_q;
  logic [NSTAGE-1:0][WIDTH-1:0] w_q;
  logic [NSTAGE-1:0][WIDTH-1:0] b_q;
  logic [NSTAGE-1:0]            c_q;   // carry into segment k+1
  logic [NSTAGE-1:0]            m_q;   // carry into segment MSB (last stage: into bit WIDTH-1)

  // Upstream view of each stage (input ports for stage 0).
  logic [NSTAGE-1:0]            up_valid;
  logic [NSTAGE-1:0][WIDTH-1:0] up_w;
  logic [NSTAGE-1:0][WIDTH-1:0] up_b;
  logic [NSTAGE-1:0]            up_c;
  logic [NSTAGE-1:0][WIDTH-1:0] w_next;

  logic [NSTAGE-1:0][SEG-1:0]   seg_s;
  logic [NSTAGE-1:0]            seg_c;
  logic [NSTAGE-1:0]            seg_m;
  logic [NSTAGE-1:0]            ready;

  always_comb begin
    up_valid    = '0;
    up_w        = '0;
    up_b        = '0;
    up_c        = '0;
    up_valid[0] = in_valid;
    up_w[0]     = a;
    up_b[0]     = sub ? ~b : b;
    up_c[0]     = sub ^ cin;
    for (int unsigned k = 1; k < NSTAGE; k++) begin
      up_valid[k] = valid_q[k-1];
      up_w[k]     = w_q[k-1];
      up_b[k]     = b_q[k-1];
      up_c[k]     = c_q[k-1];
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_seg
    addsub_seg #(.SEG(SEG)) u_seg (
      .a    (up_w[k][k*SEG +: SEG]),
      .b    (up_b[k][k*SEG +: SEG]),
      .cin  (up_c[k]),
      .s    (seg_s[k]),
      .cout (seg_c[k]),
      .cmsb (seg_m[k])
    );
  end

  always_comb begin
    w_next = up_w;
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      w_next[k][k*SEG +: SEG] = seg_s[k];
    end
  end

  // ready_k = !valid_k | ready_{k+1} unrolled: stage k can advance if out_ready
  // is high or any stage from k downstream is empty.
  always_comb begin
    ready = '0;
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      ready[k] = out_ready;
      for (int unsigned j = k; j < NSTAGE; j++) begin
        if (!valid_q[j]) ready[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      w_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      m_q     <= '0;
    end else begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        if (flush) begin
          valid_q[k] <= 1'b0;
        end else if (ready[k]) begin
          valid_q[k] <= up_valid[k];
        end
        // Data only moves with a real operation, so the last stage's outputs
        // stay put while stalled and after a bubble.
        if (ready[k] && up_valid[k]) begin
          w_q[k] <= w_next[k];
          b_q[k] <= up_b[k];
          c_q[k] <= seg_c[k];
          m_q[k] <= seg_m[k];
        end
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[NSTAGE-1];
  assign s         = w_q[NSTAGE-1];
  assign cout      = c_q[NSTAGE-1];
  assign ovf       = m_q[NSTAGE-1] ^ c_q[NSTAGE-1];
  assign zero      = (w_q[NSTAGE-1] == '0);

  // Resolved b segments and the non-final MSB carries are never read.
  logic unused_pipe;
  assign unused_pipe = ^{b_q, m_q};

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=64, SEG=16, 4 stages).
module tb_addsub_pipe;

  localparam int NST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] s;
  logic        cout;
  logic        ovf;
  logic        zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_delivered = 0;
  bit saw_stall = 1'b0;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        cin;
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  res_t sb[$];
  vec_t vecs[8];

  addsub_pipe #(.WIDTH(64), .SEG(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [63:0] ma, input logic [63:0] mb,
                                 input logic msub, input logic mcin);
    logic [64:0] sum;
    logic [63:0] bb;
    res_t r;
    bb     = msub ? ~mb : mb;
    sum    = {1'b0, ma} + {1'b0, bb} + {64'd0, msub ^ mcin};
    r.s    = sum[63:0];
    r.cout = sum[64];
    r.ovf  = (ma[63] == bb[63]) && (r.s[63] != ma[63]);
    r.zero = (r.s == 64'd0);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: samples at the falling edge, mid-cycle.
  res_t held;
  res_t e;
  bit   hold_prev = 1'b0;

  always @(negedge clk) begin
    if (hold_prev) begin
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_s", s, held.s);
      check("hold_flags", {61'd0, cout, ovf, zero}, {61'd0, held.cout, held.ovf, held.zero});
    end
    if (rst || flush) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      check("in_ready", {63'd0, in_ready}, {63'd0, (out_ready || (sb.size() < NST))});
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got s=0x%0h, expected no output", s);
        end else begin
          e = sb.pop_front();
          check("sb_s", s, e.s);
          check("sb_flags", {61'd0, cout, ovf, zero}, {61'd0, e.cout, e.ovf, e.zero});
          n_delivered++;
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, sub, cin));
      hold_prev = out_valid && !out_ready;
      held.s    = s;
      held.cout = cout;
      held.ovf  = ovf;
      held.zero = zero;
    end
  end

  task automatic send(input logic [63:0] ta, input logic [63:0] tb_, input logic ts,
                      input logic tc, output int acc);
    a = ta; b = tb_; sub = ts; cin = tc; in_valid = 1'b1;
    acc = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (acc < 0) fail("send");
  endtask

  task automatic send_rand(output int acc);
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), acc);
  endtask

  task automatic wait_out(input int acc, output int lat);
    bit seen;
    seen = 1'b0;
    lat = -1;
    for (int t = 0; t < 20; t++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (seen) lat = cyc - acc;
    else fail("wait_out");
  endtask

  task automatic drain();
    for (int t = 0; t < 40; t++) begin
      if (sb.size() == 0 && !out_valid) break;
      step();
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_vec(input int i);
    int acc;
    int lat;
    send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, acc);
    wait_out(acc, lat);
    check($sformatf("v%0d_latency", i), 64'(lat), 64'(NST - 1));
    check($sformatf("v%0d_s", i), s, vecs[i].s);
    check($sformatf("v%0d_cout", i), {63'd0, cout}, {63'd0, vecs[i].cout});
    check($sformatf("v%0d_ovf", i), {63'd0, ovf}, {63'd0, vecs[i].ovf});
    check($sformatf("v%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].zero});
    step();
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    int acc;
    int lat;
    int d0;
    res_t r;

    //        a                       b                       sub   cin   s                       cout  ovf   zero
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 1'b0, 1'b0, 64'd0,                  1'b1, 1'b0, 1'b1};
    vecs[1] = '{64'h8000_0000_0000_0000, 64'd1,                 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{64'd5,                   64'd3,                 1'b1, 1'b1, 64'd1,                  1'b1, 1'b0, 1'b0};
    vecs[3] = '{64'd0,                   64'd1,                 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{64'h0000_0000_FFFF_FFFF, 64'd1,                 1'b0, 1'b1, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{64'd5,                   64'd5,                 1'b1, 1'b0, 64'd0,                  1'b1, 1'b0, 1'b1};
    vecs[7] = '{64'h0001_0000_0000_0000, 64'd1,                 1'b1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_s", s, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd1);
    rst = 1'b0;
    step();
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed table
    for (int i = 0; i < 8; i++) run_vec(i);
    drain();

    // Stream of 10 with a 3-cycle output stall
    d0 = n_delivered;
    saw_stall = 1'b0;
    fork
      begin
        repeat (4) step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 10; i++) send_rand(acc);
    drain();
    check("stream_count", 64'(n_delivered - d0), 64'd10);
    check("stream_stall_seen", {63'd0, saw_stall}, 64'd1);

    // Flush with 3 in flight plus one presented in the flush cycle
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand(acc);
    a = 64'h1234; b = 64'h1; sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    d0 = n_delivered;
    for (int i = 0; i < 6; i++) begin
      check("flush_out_valid", {63'd0, out_valid}, 64'd0);
      step();
    end
    check("flush_none_delivered", 64'(n_delivered - d0), 64'd0);
    send(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, acc);
    r = model(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0);
    wait_out(acc, lat);
    check("post_flush_latency", 64'(lat), 64'(NST - 1));
    check("post_flush_s", s, r.s);
    step();
    drain();

    // Reset mid-stream
    send_rand(acc);
    send_rand(acc);
    a = 64'hDEAD; b = 64'hBEEF; in_valid = 1'b1;
    rst = 1'b1;
    step();
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_s", s, 64'd0);
    check("midrst_zero", {63'd0, zero}, 64'd1);
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    run_vec(1);
    run_vec(2);
    d0 = n_delivered;
    for (int i = 0; i < 5; i++) send_rand(acc);
    drain();
    check("resume_count", 64'(n_delivered - d0), 64'd5);

    summary();
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before timeout");
    errors++;
    summary();
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined integer adder/subtractor for the execute-stage arithmetic path (wide MUL/DIV accumulation, HI/LO add/sub). Operands are split into SEG-bit segments, and one segment is resolved per pipeline stage with a registered inter-segment carry. This gives full throughput of one operation per cycle at a fixed latency of NSTAGE cycles. A valid/ready handshake on both sides and a flush for exception/branch squash make it safe to stall and cancel.

## Interface
- WIDTH, 64: operand and result width; must be a multiple of SEG.
- SEG, 16: segment width resolved per stage; NSTAGE = WIDTH/SEG (≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all in-flight operations.
- in_valid  in  1  operand set is valid.
- in_ready  out  1  block accepts the operand set this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  1 = subtract.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result this cycle.
- s  out  WIDTH  result.
- cout  out  1  carry out of the MSB; in subtract mode, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  s == 0.

## Operation
- Arithmetic: s = a + (sub ? ~b : b) + (sub ^ cin), mod 2^WIDTH.
  - sub=1, cin=1 gives a−b−1 (borrow chain).
  - cout is the true carry out of bit WIDTH−1.
  - ovf = carry into MSB XOR carry out of MSB.
- Handshake:
  - An operation is accepted when in_valid & in_ready.
  - It is delivered when out_valid & out_ready.
  - Accepted operations are delivered exactly once, in order, with no bubbles injected while the output is ready.
- Stage k (0..NSTAGE−1) holds:
  - valid_k;
  - result segments 0..k, resolved;
  - operand segments k+1..NSTAGE−1, still pending, with b already conditionally inverted;
  - the carry into segment k+1;
  - the carry into the MSB, in the last stage only.
- Stage 0 resolves segment 0 using carry-in (sub ^ cin).
- Stage k advances when ready_k = !valid_k | ready_{k+1}, with ready_NSTAGE = out_ready. in_ready = ready_0 (a combinational ready chain is acceptable).
- out_valid = valid_{NSTAGE−1}. s, cout, ovf and zero are driven from the last stage's registers and are held stable while out_valid & !out_ready.
- flush: clears every valid_k at the next edge.
  - An operation presented in the flush cycle is discarded, even if in_ready was high.
  - Data registers need not be cleared.
- rst: identical effect to flush, and additionally zeroes the data registers.
- rst and flush together: rst behaviour.

## Timing
- Reset values: out_valid=0, s=0, cout=0, ovf=0, zero=1. in_ready=1 from the first cycle after reset.
- Latency: an operation accepted at edge t produces out_valid high after edge t+NSTAGE−1, i.e. NSTAGE cycles from input to output.
- Throughput: 1 operation per cycle while out_ready=1.
- Back-pressure:
  - With out_ready=0, the pipeline fills.
  - in_ready drops once all NSTAGE stages are valid.
  - in_ready rises in the same cycle out_ready returns high.
- Critical path: one SEG-bit carry-lookahead plus the registered carry. No WIDTH-wide carry chain exists.
- NSTAGE=1: purely a registered adder; latency 1; same handshake.

## Structure
- Shared package addsub_pkg holds the default WIDTH/SEG constants and the NSTAGE derivation function.
- Sub-module addsub_seg: a combinational SEG-bit carry-lookahead segment with inputs a, b, cin and outputs s, cout, and carry into the segment MSB. It is instantiated once per stage.
- Top level: per-stage registers, handshake chain, flag generation.

## Test plan
All scenarios use WIDTH=64, SEG=16 (NSTAGE=4).
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0, cin=0 → s=0, cout=1, ovf=0, zero=1; out_valid exactly 4 cycles after acceptance.
- Signed overflow: a=0x8000_0000_0000_0000, b=1, sub=1, cin=0 → s=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
- Subtract with borrow:
  - a=5, b=3, sub=1, cin=1 → s=1, cout=1.
  - a=0, b=1, sub=1, cin=0 → s=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0.
- Stream of 10 random operations (continuous in_valid) with out_ready low for 3 cycles mid-stream:
  - in_ready drops after 4 operations are held;
  - all 10 results match the reference model, in order, with no duplicates;
  - results are stable while stalled.
- Flush with 3 operations in flight and a 4th presented in the flush cycle → none are delivered; the next operation is accepted and delivered 4 cycles later.
- Reset asserted mid-stream → out_valid=0, s=0, zero=1 the following cycle; normal operation resumes afterwards.
